keypad_cursor_input: RTL and testbench
======================================

KEYPAD_CURSOR_INPUT -- requirements
Module: keypad_cursor_input

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000: consecutive identical synchronized samples required to accept a button level change.
REQ-002 Parameter REPEAT_DELAY, default 50000000: cycles a direction button must be held before auto-repeat starts.
REQ-003 Parameter REPEAT_PERIOD, default 15000000: cycles between auto-repeat moves.
REQ-004 clk  input  1  clock.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 btn_u, btn_d, btn_l, btn_r, btn_c  input  1 each  raw asynchronous push-buttons: up, down, left, right, center.
REQ-007 val  output  5  key code under the cursor, registered.
REQ-008 enter_button  output  1  one-cycle pulse; the key in val is pressed.
REQ-009 cursor_row  output  3  cursor row, 0..5, for screen highlight.
REQ-010 cursor_col  output  2  cursor column, 0..3, for screen highlight.

Function
REQ-011 Key grid SHALL be 6 rows x 4 columns; val SHALL equal row*4+col at all times (0x00-0x0F digits, 0x10-0x17 operators/commands).
REQ-012 Each button SHALL pass a 2-flop synchronizer, then a debouncer whose stable level changes only after DEBOUNCE_CYCLES consecutive samples differ from it.
REQ-013 A press event SHALL be a one-cycle rising edge of the debounced level; falling edges generate nothing.
REQ-014 Latency from first synchronizer sample of a clean press to its effect (enter_button high or cursor moved) SHALL be exactly DEBOUNCE_CYCLES+3 cycles.
REQ-015 Center event: enter_button SHALL be high exactly one cycle; val SHALL be unchanged in that cycle and the next.
REQ-016 Up/down SHALL decrement/increment row, wrapping 0<->5; left/right SHALL decrement/increment column, wrapping 0<->3, row unchanged.
REQ-017 Simultaneous events in one cycle: only the highest-priority one is acted on (center > up > down > left > right); the others are discarded.
REQ-018 Auto-repeat FSM, states IDLE, HOLD, REPEAT: IDLE->HOLD on a direction event (move applied); HOLD->REPEAT after REPEAT_DELAY cycles with the same debounced direction still high (one move); in REPEAT, one move every REPEAT_PERIOD cycles; any state->IDLE when the tracked direction's debounced level falls.
REQ-019 While in HOLD/REPEAT, a new event on another button SHALL be processed normally and SHALL make that button the tracked direction (center returns the FSM to IDLE).
REQ-020 Center SHALL never auto-repeat; holding btn_c SHALL produce exactly one enter_button pulse.
REQ-021 Bounce shorter than DEBOUNCE_CYCLES SHALL produce no event.

Reset
REQ-022 On rst: cursor_row=0, cursor_col=0, val=0x00, enter_button=0, FSM=IDLE, all debounced levels 0, all counters 0, all synchronizer flops 0.
REQ-023 rst mid-press SHALL abort any pending event; a button still held after rst deasserts SHALL produce one event DEBOUNCE_CYCLES+3 cycles later.

Structure
REQ-024 Package calc_keys_pkg SHALL hold GRID_ROWS=6, GRID_COLS=4, key constants KEY_EXEC=5'h13, KEY_BACK=5'h16, KEY_CLEAR=5'h17, and the FSM state enum.
REQ-025 Sub-module button_debouncer (synchronizer + counter + edge pulse, parameter DEBOUNCE_CYCLES) SHALL be instantiated five times.
REQ-026 enter_button and val SHALL connect directly to the calculator input FSM's enter_button and val inputs.

Verification (bench parameters DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8)
REQ-027 After reset, btn_r held 10 cycles -> cursor_col=1, val=0x01 exactly 7 cycles after the first sample; no further move.
REQ-028 At (0,0), btn_u pressed once -> row=5, val=0x14; then btn_l once -> col=3, val=0x17.
REQ-029 btn_c held 100 cycles at (4,3) -> single enter_button pulse with val=0x13.
REQ-030 btn_d held 60 cycles from row 0 -> moves at latency 7, +20, +28, +36 relative to first sample (rows 1,2,3,4); release -> IDLE, no further move.
REQ-031 btn_c and btn_r rising in the same cycle -> enter_button pulse only; cursor unchanged.
REQ-032 btn_l toggling every 2 cycles for 40 cycles -> no move; rst asserted during a held btn_r -> outputs return to reset values and one move occurs 7 cycles after rst deasserts.

Source files
------------

// File: rtl/calc_keys_pkg.sv
// Shared constants and types for the calculator keypad cursor logic.
// The key grid is addressed as {row, col}, so a key code is row*4+col.
package calc_keys_pkg;

    localparam int GRID_ROWS = 6;
    localparam int GRID_COLS = 4;

    localparam logic [4:0] KEY_EXEC  = 5'h13;
    localparam logic [4:0] KEY_BACK  = 5'h16;
    localparam logic [4:0] KEY_CLEAR = 5'h17;

    // Bit positions of the buttons in the packed button vectors.
    // The order of the four directions is also their priority order.
    localparam int BTN_U = 0;
    localparam int BTN_D = 1;
    localparam int BTN_L = 2;
    localparam int BTN_R = 3;
    localparam int BTN_C = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } rpt_state_e;

    typedef enum logic [1:0] {
        DIR_U = 2'd0,
        DIR_D = 2'd1,
        DIR_L = 2'd2,
        DIR_R = 2'd3
    } dir_e;

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer, consecutive-sample debouncer and rising-edge pulse
// for one raw push-button.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic             stable_dly_q;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        // Any sample matching the stable level restarts the run count.
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press_d = stable_q & ~stable_dly_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            press_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= btn_raw;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            press_q      <= press_d;
            cnt_q        <= cnt_d;
        end
    end

    assign level = stable_q;
    assign press = press_q;

endmodule

// File: rtl/keypad_cursor_input.sv
// Five debounced buttons drive a cursor over the 6x4 key grid, with
// auto-repeat on held direction buttons and an enter pulse on center.
//
// state     | meaning
// ST_IDLE   | no direction being tracked
// ST_HOLD   | direction moved once, waiting out the repeat delay
// ST_REPEAT | direction still held, moving once per repeat period
module keypad_cursor_input
    import calc_keys_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 15000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_u,
    input  logic       btn_d,
    input  logic       btn_l,
    input  logic       btn_r,
    input  logic       btn_c,
    output logic [4:0] val,
    output logic       enter_button,
    output logic [2:0] cursor_row,
    output logic [1:0] cursor_col
);

    localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TMR_W   = $clog2(TMR_MAX) + 1;
    localparam logic [TMR_W-1:0] DELAY_LD  = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] PERIOD_LD = TMR_W'(REPEAT_PERIOD - 1);
    localparam logic [2:0]       ROW_MAX   = 3'(GRID_ROWS - 1);
    localparam logic [1:0]       COL_MAX   = 2'(GRID_COLS - 1);

    logic [4:0] raw, lvl, prs;

    assign raw = {btn_c, btn_r, btn_l, btn_d, btn_u};

    for (genvar i = 0; i < 5; i++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk    (clk),
            .rst    (rst),
            .btn_raw(raw[i]),
            .level  (lvl[i]),
            .press  (prs[i])
        );
    end

    rpt_state_e       state_q, state_d;
    dir_e             dir_q, dir_d;
    dir_e             ev_dir, move_dir;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [2:0]       row_q, row_d;
    logic [1:0]       col_q, col_d;
    logic [4:0]       val_q, val_d;
    logic             enter_q, enter_d;
    logic             do_move;

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        tmr_d    = tmr_q;
        row_d    = row_q;
        col_d    = col_q;
        enter_d  = 1'b0;
        do_move  = 1'b0;
        move_dir = dir_q;

        ev_dir = DIR_R;
        for (int i = 3; i >= 0; i--) begin
            if (prs[i]) ev_dir = dir_e'(2'(i));
        end

        if (prs[BTN_C]) begin
            enter_d = 1'b1;
            state_d = ST_IDLE;
        end else if (|prs[3:0]) begin
            do_move  = 1'b1;
            move_dir = ev_dir;
            dir_d    = ev_dir;
            state_d  = ST_HOLD;
            tmr_d    = DELAY_LD;
        end else if (state_q != ST_IDLE) begin
            if (!lvl[dir_q]) begin
                state_d = ST_IDLE;
            end else if (tmr_q == '0) begin
                do_move = 1'b1;
                state_d = ST_REPEAT;
                tmr_d   = PERIOD_LD;
            end else begin
                tmr_d = tmr_q - 1'b1;
            end
        end

        if (do_move) begin
            case (move_dir)
                DIR_U:   row_d = (row_q == 3'd0)   ? ROW_MAX : row_q - 1'b1;
                DIR_D:   row_d = (row_q == ROW_MAX) ? 3'd0    : row_q + 1'b1;
                DIR_L:   col_d = (col_q == 2'd0)   ? COL_MAX : col_q - 1'b1;
                default: col_d = (col_q == COL_MAX) ? 2'd0    : col_q + 1'b1;
            endcase
        end

        val_d = {row_d, col_d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_U;
            tmr_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            val_q   <= '0;
            enter_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            tmr_q   <= tmr_d;
            row_q   <= row_d;
            col_q   <= col_d;
            val_q   <= val_d;
            enter_q <= enter_d;
        end
    end

    assign val          = val_q;
    assign enter_button = enter_q;
    assign cursor_row   = row_q;
    assign cursor_col   = col_q;

endmodule

// File: tb/tb_keypad_cursor_input.sv
// Directed bench for keypad_cursor_input with short debounce/repeat timings.
module tb_keypad_cursor_input;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] btn = '0;  // {c, r, l, d, u}
    logic [4:0] val;
    logic       enter_button;
    logic [2:0] cursor_row;
    logic [1:0] cursor_col;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [4:0] B_U = 5'b00001;
    localparam logic [4:0] B_D = 5'b00010;
    localparam logic [4:0] B_L = 5'b00100;
    localparam logic [4:0] B_R = 5'b01000;
    localparam logic [4:0] B_C = 5'b10000;

    always #5 clk = ~clk;

    keypad_cursor_input #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_u       (btn[0]),
        .btn_d       (btn[1]),
        .btn_l       (btn[2]),
        .btn_r       (btn[3]),
        .btn_c       (btn[4]),
        .val         (val),
        .enter_button(enter_button),
        .cursor_row  (cursor_row),
        .cursor_col  (cursor_col)
    );

    typedef struct {
        logic [4:0] btn;
        int         row;
        int         col;
        int         enters;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Hold a button pattern, release it, let everything settle; count pulses.
    task automatic press(input logic [4:0] m, input int hold, output int enters);
        enters = 0;
        btn = m;
        repeat (hold) begin
            cyc();
            if (enter_button) enters++;
        end
        btn = '0;
        repeat (20) begin
            cyc();
            if (enter_button) enters++;
        end
    endtask

    task automatic chk_pos(input string name, input int r, input int c);
        chk({name, " row"}, int'(cursor_row), r);
        chk({name, " col"}, int'(cursor_col), c);
        chk({name, " val"}, int'(val), r * 4 + c);
    endtask

    initial begin
        int n;
        int prev_row;
        int chg_t[$];
        int chg_r[$];
        logic prev_enter;

        vecs[0]  = '{B_R,       0, 2, 0};
        vecs[1]  = '{B_R,       0, 3, 0};
        vecs[2]  = '{B_R,       0, 0, 0};
        vecs[3]  = '{B_U,       5, 0, 0};
        vecs[4]  = '{B_L,       5, 3, 0};
        vecs[5]  = '{B_D,       0, 3, 0};
        vecs[6]  = '{B_L,       0, 2, 0};
        vecs[7]  = '{B_D,       1, 2, 0};
        vecs[8]  = '{B_U,       0, 2, 0};
        vecs[9]  = '{B_C,       0, 2, 1};
        vecs[10] = '{B_U | B_D, 5, 2, 0};
        vecs[11] = '{B_L | B_R, 5, 1, 0};
        vecs[12] = '{B_D | B_L, 0, 1, 0};

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_pos("reset", 0, 0);
        chk("reset enter", int'(enter_button), 0);
        rst = 1'b0;
        repeat (5) cyc();

        // Right held 10 cycles: move lands exactly 7 cycles after first sample
        btn = B_R;
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (k == 6) chk("r latency early col", int'(cursor_col), 0);
            if (k == 7) begin
                chk("r latency col", int'(cursor_col), 1);
                chk("r latency val", int'(val), 1);
            end
        end
        btn = '0;
        repeat (25) cyc();
        chk_pos("r single move", 0, 1);

        // Single presses and simultaneous-press priority
        for (int i = 0; i < 13; i++) begin
            press(vecs[i].btn, 10, n);
            chk_pos($sformatf("vec%0d", i), vecs[i].row, vecs[i].col);
            chk($sformatf("vec%0d enters", i), n, vecs[i].enters);
        end

        // Walk to (4,3) and hold center for 100 cycles
        repeat (4) press(B_D, 10, n);
        repeat (2) press(B_R, 10, n);
        chk_pos("at exec", 4, 3);
        n = 0;
        prev_enter = 1'b0;
        btn = B_C;
        for (int k = 0; k < 120; k++) begin
            if (k == 100) btn = '0;
            cyc();
            if (enter_button) begin
                n++;
                chk("enter val", int'(val), 19);
            end
            if (prev_enter) chk("val after enter", int'(val), 19);
            prev_enter = enter_button;
        end
        chk("center hold pulses", n, 1);

        // Center and right together: enter only
        press(B_C | B_R, 10, n);
        chk("c+r enters", n, 1);
        chk_pos("c+r", 4, 3);

        // Down held from row 0: moves at 7, 27, 35, 43
        press(B_D, 10, n);
        press(B_D, 10, n);
        chk_pos("repeat start", 0, 3);
        prev_row = int'(cursor_row);
        btn = B_D;
        for (int k = 0; k < 90; k++) begin
            if (k == 44) btn = '0;
            cyc();
            if (int'(cursor_row) != prev_row) begin
                chg_t.push_back(k);
                chg_r.push_back(int'(cursor_row));
            end
            prev_row = int'(cursor_row);
        end
        chk("repeat move count", chg_t.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < chg_t.size()) begin
                chk($sformatf("repeat move%0d time", i), chg_t[i], (i == 0) ? 7 : 19 + 8 * i);
                chk($sformatf("repeat move%0d row", i), chg_r[i], i + 1);
            end
        end
        chk_pos("after repeat", 4, 3);

        // Left bouncing every 2 cycles: nothing happens
        n = 0;
        for (int k = 0; k < 60; k++) begin
            btn = (k < 40 && ((k / 2) % 2 == 0)) ? B_L : 5'b0;
            cyc();
            if (enter_button) n++;
        end
        btn = '0;
        chk_pos("bounce", 4, 3);
        chk("bounce enters", n, 0);

        // Reset in the middle of a held right press
        btn = B_R;
        repeat (5) cyc();
        rst = 1'b1;
        repeat (3) cyc();
        chk_pos("mid-press reset", 0, 0);
        chk("mid-press reset enter", int'(enter_button), 0);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            cyc();
            if (k == 6) chk("post-reset early col", int'(cursor_col), 0);
            if (k == 7) chk("post-reset move col", int'(cursor_col), 1);
        end
        btn = '0;
        repeat (25) cyc();
        chk_pos("post-reset final", 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
